// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller.
// Eight lines of one 32-bit block each. Byte-addressed CPU side, block-wide memory side.
// Every output is a register, loaded from the next-cycle values computed in the FSM.
module cache_ctrl #(
  parameter int NLINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_wrt_bck,
  output logic        mem_fetch,
  input  logic        mem_cmplt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // Request latched in IDLE so later CPU-side changes cannot disturb it
  logic [23:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_is_wr;

  // Line storage
  logic [31:0]       r_data  [NLINES];
  logic [18:0]       r_tag   [NLINES];
  logic [NLINES-1:0] r_valid;
  logic [NLINES-1:0] r_dirty;

  // Registered outputs and their next-cycle values
  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_ready;
  logic [23:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_wrt_bck;
  logic        r_mem_fetch;
  logic        w_cpu_ready;
  logic [23:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_mem_wrt_bck;
  logic        w_mem_fetch;

  logic [18:0] w_tag;
  logic [2:0]  w_idx;
  logic [1:0]  w_off;
  logic        w_hit;
  logic        w_accept;

  function automatic logic [7:0] f_get_byte(input logic [31:0] d, input logic [1:0] off);
    return d[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] f_put_byte(input logic [31:0] d, input logic [1:0] off,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = d;
    r[{off, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign w_tag = r_addr[23:5];
  assign w_idx = r_addr[4:2];
  assign w_off = r_addr[1:0];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // The cycle in which cpu_ready is high is the one where the CPU is still dropping its
  // request, so a new request is only taken once that pulse is over.
  assign w_accept = (cpu_rd || cpu_wr) && !r_cpu_ready;

  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ready   = r_cpu_ready;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wrt_bck = r_mem_wrt_bck;
  assign mem_fetch   = r_mem_fetch;

  // Next state and next-cycle values of the registered outputs
  always_comb begin
    w_next_state  = r_state;
    w_cpu_ready   = 1'b0;
    w_mem_addr    = r_mem_addr;
    w_mem_wdata   = r_mem_wdata;
    w_mem_wrt_bck = 1'b0;
    w_mem_fetch   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          w_next_state = S_RESP;
        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
          w_next_state  = S_WRITEBACK;
          w_mem_wrt_bck = 1'b1;
          w_mem_addr    = {r_tag[w_idx], w_idx, 2'b00};
          w_mem_wdata   = r_data[w_idx];
        end else begin
          w_next_state = S_ALLOCATE;
          w_mem_fetch  = 1'b1;
          w_mem_addr   = {w_tag, w_idx, 2'b00};
        end
      end
      S_WRITEBACK: begin
        if (mem_cmplt) begin
          w_next_state = S_ALLOCATE;
          w_mem_fetch  = 1'b1;
          w_mem_addr   = {w_tag, w_idx, 2'b00};
        end else begin
          w_mem_wrt_bck = 1'b1;
        end
      end
      S_ALLOCATE: begin
        if (mem_cmplt) w_next_state = S_COMPARE;
        else           w_mem_fetch  = 1'b1;
      end
      S_RESP: begin
        w_next_state = S_IDLE;
        w_cpu_ready  = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Control state: FSM, valid/dirty bits and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_cpu_ready   <= 1'b0;
      r_cpu_rdata   <= 8'h00;
      r_mem_addr    <= 24'h0;
      r_mem_wdata   <= 32'h0;
      r_mem_wrt_bck <= 1'b0;
      r_mem_fetch   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cpu_ready   <= w_cpu_ready;
      r_mem_addr    <= w_mem_addr;
      r_mem_wdata   <= w_mem_wdata;
      r_mem_wrt_bck <= w_mem_wrt_bck;
      r_mem_fetch   <= w_mem_fetch;
      if (r_state == S_COMPARE && w_hit) begin
        if (r_is_wr) r_dirty[w_idx] <= 1'b1;
        else         r_cpu_rdata    <= f_get_byte(r_data[w_idx], w_off);
      end
      if (r_state == S_WRITEBACK && mem_cmplt) r_dirty[w_idx] <= 1'b0;
      if (r_state == S_ALLOCATE && mem_cmplt) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  // Request latch and line data/tag arrays (no reset needed)
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
      r_is_wr <= cpu_wr;
    end
    if (r_state == S_COMPARE && w_hit && r_is_wr)
      r_data[w_idx] <= f_put_byte(r_data[w_idx], w_off, r_wdata);
    if (!rst && r_state == S_ALLOCATE && mem_cmplt) begin
      r_data[w_idx] <= mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a table of CPU transactions with a small memory
// responder, plus hand-written sequences for reset, stray completion and abort.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_wrt_bck;
  logic        mem_fetch;
  logic        mem_cmplt;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  cache_ctrl #(.NLINES(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_wrt_bck(mem_wrt_bck), .mem_fetch(mem_fetch), .mem_cmplt(mem_cmplt)
  );

  // Both memory strobes must never be high together
  always @(negedge clk) if (mem_fetch === 1'b1 && mem_wrt_bck === 1'b1) overlap++;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [31:0] mrd;
    logic        exp_fetch;
    logic [23:0] exp_faddr;
    logic        exp_wb;
    logic [23:0] exp_wbaddr;
    logic [31:0] exp_wbdata;
    logic        chk_rdata;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  logic        obs_fetch, obs_wb;
  logic [23:0] obs_faddr, obs_wbaddr;
  logic [31:0] obs_wbdata;
  logic [7:0]  obs_rdata;
  int          obs_ready_cnt, obs_lat, obs_stuck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one CPU request, act as memory (completes each strobe after two cycles)
  task automatic run_txn(input vec_t v);
    int  wait_c;
    int  post;
    logic pf, pw;
    obs_fetch = 0; obs_wb = 0; obs_faddr = '0; obs_wbaddr = '0; obs_wbdata = '0;
    obs_rdata = '0; obs_ready_cnt = 0; obs_lat = 0; obs_stuck = 0;
    wait_c = 0; post = 0; pf = 0; pw = 0;
    @(negedge clk);
    cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    for (int c = 1; c <= 60 && post < 2; c++) begin
      @(negedge clk);
      mem_cmplt = 1'b0;
      if (pf && mem_fetch) obs_stuck++;
      if (pw && mem_wrt_bck) obs_stuck++;
      pf = 0; pw = 0;
      if (mem_wrt_bck) begin
        obs_wb = 1; obs_wbaddr = mem_addr; obs_wbdata = mem_wdata;
      end
      if (mem_fetch) begin
        obs_fetch = 1; obs_faddr = mem_addr;
      end
      if (mem_fetch || mem_wrt_bck) begin
        wait_c++;
        if (wait_c == 2) begin
          mem_cmplt = 1'b1; mem_rdata = v.mrd;
          pf = mem_fetch; pw = mem_wrt_bck; wait_c = 0;
        end
      end
      if (cpu_ready) begin
        obs_ready_cnt++;
        if (obs_ready_cnt == 1) begin
          obs_rdata = cpu_rdata; obs_lat = c;
        end
        cpu_rd = 0; cpu_wr = 0;
        // CPU-side inputs may change freely once the request is latched
        cpu_addr = 24'hFFFFFF; cpu_wdata = 8'hEE;
      end
      if (obs_ready_cnt > 0) post++;
    end
    cpu_rd = 0; cpu_wr = 0; mem_cmplt = 0;
  endtask

  initial begin
    rst = 1; cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = '0;
    mem_rdata = '0; mem_cmplt = 0;

    //        rd wr addr         wd     mrd           f  faddr        wb wbaddr       wbdata        cr rdata  lat
    vecs[0] = '{1, 0, 24'h000002, 8'h00, 32'h44332211, 1, 24'h000000, 0, 24'h0,      32'h0,        1, 8'h33, 0};
    vecs[1] = '{1, 0, 24'h000001, 8'h00, 32'h0,        0, 24'h0,      0, 24'h0,      32'h0,        1, 8'h22, 3};
    vecs[2] = '{0, 1, 24'h000003, 8'h44, 32'h0,        0, 24'h0,      0, 24'h0,      32'h0,        0, 8'h00, 3};
    vecs[3] = '{1, 0, 24'h000023, 8'h00, 32'hDDCCBBAA, 1, 24'h000020, 1, 24'h000000, 32'h44332211, 1, 8'hDD, 0};
    vecs[4] = '{1, 1, 24'h000000, 8'hAA, 32'h44332211, 1, 24'h000000, 0, 24'h0,      32'h0,        0, 8'h00, 0};
    vecs[5] = '{1, 0, 24'h000000, 8'h00, 32'h0,        0, 24'h0,      0, 24'h0,      32'h0,        1, 8'hAA, 3};
    vecs[6] = '{1, 0, 24'h00001C, 8'h00, 32'h01020304, 1, 24'h00001C, 0, 24'h0,      32'h0,        1, 8'h04, 0};
    vecs[7] = '{0, 1, 24'h00001E, 8'h5A, 32'h0,        0, 24'h0,      0, 24'h0,      32'h0,        0, 8'h00, 3};
    vecs[8] = '{1, 0, 24'h00003E, 8'h00, 32'h11111111, 1, 24'h00003C, 1, 24'h00001C, 32'h015A0304, 1, 8'h11, 0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_fetch", mem_fetch, 0);
    chk("rst_wb", mem_wrt_bck, 0);
    chk("rst_maddr", mem_addr, 24'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);

    // Table-driven transactions
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i]);
      chk($sformatf("v%0d_ready_once", i), obs_ready_cnt, 1);
      chk($sformatf("v%0d_fetch", i), obs_fetch, vecs[i].exp_fetch);
      if (vecs[i].exp_fetch) chk($sformatf("v%0d_faddr", i), obs_faddr, vecs[i].exp_faddr);
      chk($sformatf("v%0d_wb", i), obs_wb, vecs[i].exp_wb);
      if (vecs[i].exp_wb) begin
        chk($sformatf("v%0d_wbaddr", i), obs_wbaddr, vecs[i].exp_wbaddr);
        chk($sformatf("v%0d_wbdata", i), obs_wbdata, vecs[i].exp_wbdata);
      end
      if (vecs[i].chk_rdata) chk($sformatf("v%0d_rdata", i), obs_rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_lat != 0) chk($sformatf("v%0d_latency", i), obs_lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_strobe_drop", i), obs_stuck, 0);
    end

    // Stray completion in IDLE changes nothing
    @(negedge clk);
    mem_cmplt = 1; mem_rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    chk("stray_ready", cpu_ready, 0);
    chk("stray_fetch", mem_fetch, 0);
    chk("stray_wb", mem_wrt_bck, 0);
    chk("stray_maddr", mem_addr, 24'h00003C);
    chk("stray_rdata", cpu_rdata, 8'h11);
    mem_cmplt = 0;
    run_txn('{1, 0, 24'h00003C, 8'h00, 32'h0, 0, 24'h0, 0, 24'h0, 32'h0, 1, 8'h11, 3});
    chk("stray_reread_fetch", obs_fetch, 0);
    chk("stray_reread_rdata", obs_rdata, 8'h11);
    chk("stray_reread_lat", obs_lat, 3);

    // Reset in the middle of a fetch aborts it
    begin
      int  seen;
      int  rdy;
      seen = 0; rdy = 0;
      @(negedge clk);
      cpu_rd = 1; cpu_addr = 24'h00000C;
      for (int c = 0; c < 20 && seen == 0; c++) begin
        @(negedge clk);
        if (mem_fetch) seen = 1;
      end
      chk("abort_fetch_seen", seen, 1);
      chk("abort_fetch_addr", mem_addr, 24'h00000C);
      rst = 1;
      @(negedge clk);
      chk("abort_fetch_low", mem_fetch, 0);
      chk("abort_maddr_rst", mem_addr, 24'h0);
      if (cpu_ready) rdy++;
      rst = 0; cpu_rd = 0;
      repeat (4) begin
        @(negedge clk);
        if (cpu_ready) rdy++;
      end
      chk("abort_no_ready", rdy, 0);
    end
    run_txn('{1, 0, 24'h00000C, 8'h00, 32'h99887766, 1, 24'h00000C, 0, 24'h0, 32'h0, 1, 8'h66, 0});
    chk("abort_reread_ready", obs_ready_cnt, 1);
    chk("abort_reread_fetch", obs_fetch, 1);
    chk("abort_reread_faddr", obs_faddr, 24'h00000C);
    chk("abort_reread_rdata", obs_rdata, 8'h66);

    chk("no_strobe_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
